// File: rtl/countdown_timer.sv
// Loadable down-counter with start/stop control, TICK_DIV prescaler and a one-cycle expired pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the last loaded value at terminal count instead of stopping in DONE.
module countdown_timer #(
  parameter int DATA_WIDTH = 16,
  parameter int TICK_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic                  start,
  input  logic                  stop,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  running,
  output logic                  expired
);

  localparam int              PRE_W   = $clog2(TICK_DIV) + 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] prescaler;
  logic             tick;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [DATA_WIDTH-1:0] reload_reg;
`endif

  // A decrement is due on the edge where the prescaler sits at its last value.
  assign tick = (prescaler == PRE_MAX);

  // NOTE: all state lives in one clocked block with non-blocking assignments, so every
  // register samples the pre-edge values and the if/else chain encodes the edge priority.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      count     <= '0;
      prescaler <= '0;
      running   <= 1'b0;
      expired   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_reg <= '0;
`endif
    end else begin
      expired <= 1'b0;
      if (load) begin
        count     <= load_value;
        prescaler <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_reg <= load_value;
`endif
        if (start && !stop && (load_value != '0)) begin
          state   <= RUN;
          running <= 1'b1;
        end else begin
          state   <= IDLE;
          running <= 1'b0;
        end
      end else if (stop) begin
        // Pausing drops any partial tick; resume restarts a full TICK_DIV period.
        state     <= IDLE;
        running   <= 1'b0;
        prescaler <= '0;
      end else if (state == RUN) begin
        if (tick) begin
          prescaler <= '0;
          if (count == DATA_WIDTH'(1)) begin
            expired <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            count   <= reload_reg;
`else
            count   <= '0;
            state   <= DONE;
            running <= 1'b0;
`endif
          end else begin
            count <= count - 1'b1;
          end
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end else if (start && (state == IDLE) && (count != '0)) begin
        state   <= RUN;
        running <= 1'b1;
      end
    end
  end

endmodule
